// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RV32 controller: state encoding,
// opcode constants, immediate-format and ALU operation codes.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_LUI      = 4'd11
  } state_t;

  // Coarse ALU request from the FSM; the decoder refines FUNCT using funct3/funct7.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  function automatic logic [2:0] imm_sel(input logic [6:0] opcode);
    case (opcode)
      OP_LOAD, OP_ITYPE: imm_sel = IMM_I;
      OP_STORE:          imm_sel = IMM_S;
      OP_BRANCH:         imm_sel = IMM_B;
      OP_JAL:            imm_sel = IMM_J;
      OP_LUI:            imm_sel = IMM_U;
      default:           imm_sel = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus instruction funct fields to an
// alucontrol code.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  // Subtract only for R-type (op5 set) with funct7b5; addi never subtracts.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: begin
            if (op5 && funct7b5) alucontrol = ALU_SUB;
            else                 alucontrol = ALU_ADD;
          end
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main FSM of a multicycle RV32 subset datapath: sequences fetch, decode,
// memory, execute and writeback steps and drives every datapath control.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [2:0] immsrc,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol
);

  state_t state_q, state_d;
  aluop_t aluop_s;

  // State register; reset parks the machine in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and Moore-style control decode.
  always_comb begin
    state_d   = S_FETCH;
    pcwrite   = 1'b0;
    adrsrc    = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    resultsrc = 2'b00;
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    aluop_s   = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        state_d   = S_DECODE;
        irwrite   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        pcwrite   = 1'b1;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        if (op == OP_STORE) state_d = S_MEMWRITE;
        else                state_d = S_MEMREAD;
      end
      S_MEMREAD: begin
        state_d = S_MEMWB;
        adrsrc  = 1'b1;
      end
      S_MEMWB: begin
        state_d   = S_FETCH;
        resultsrc = 2'b01;
        regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        state_d  = S_FETCH;
        adrsrc   = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTER: begin
        state_d = S_ALUWB;
        alusrca = 2'b10;
        aluop_s = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        state_d = S_ALUWB;
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop_s = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        state_d  = S_FETCH;
        regwrite = 1'b1;
      end
      S_JAL: begin
        state_d = S_ALUWB;
        alusrca = 2'b01;
        alusrcb = 2'b10;
        pcwrite = 1'b1;
      end
      S_BRANCH: begin
        state_d = S_FETCH;
        alusrca = 2'b10;
        aluop_s = ALUOP_SUB;
        // Only beq/bne are supported; other branch funct3 never redirects.
        case (funct3)
          3'b000:  pcwrite = zero;
          3'b001:  pcwrite = ~zero;
          default: pcwrite = 1'b0;
        endcase
      end
      S_LUI: begin
        state_d = S_ALUWB;
        alusrca = 2'b11;
        alusrcb = 2'b01;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // The extender format follows the live opcode regardless of state.
  always_comb begin
    immsrc = imm_sel(op);
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop_s),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: directed and random instructions compared cycle by
// cycle against a phase-list reference model.
module tb_multicycle_controller;

  logic       clk, rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero;
  logic [2:0] immsrc, alucontrol;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite;
  logic [1:0] resultsrc, alusrca, alusrcb;

  int n_cmp  = 0;
  int n_fail = 0;
  int seq[5];
  int seq_len;

  localparam int PH_F = 0, PH_D = 1, PH_MA = 2, PH_MR = 3, PH_MWB = 4, PH_MW = 5,
                 PH_ER = 6, PH_EI = 7, PH_AWB = 8, PH_J = 9, PH_B = 10, PH_L = 11;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .immsrc(immsrc), .pcwrite(pcwrite), .adrsrc(adrsrc),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .alucontrol(alucontrol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] ref_imm(input logic [6:0] o);
    if (o == 7'b0000011 || o == 7'b0010011) return 3'b000;
    if (o == 7'b0100011) return 3'b001;
    if (o == 7'b1100011) return 3'b010;
    if (o == 7'b1101111) return 3'b011;
    if (o == 7'b0110111) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [2:0] ref_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (f3 == 3'd0) return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'd2) return 3'b101;
    if (f3 == 3'd6) return 3'b011;
    if (f3 == 3'd7) return 3'b010;
    return 3'b000;
  endfunction

  // Phase list of one instruction, from its opcode class.
  task automatic build_seq(input logic [6:0] o);
    seq[0] = PH_F; seq[1] = PH_D; seq_len = 2;
    if (o == 7'b0000011) begin seq[2] = PH_MA; seq[3] = PH_MR; seq[4] = PH_MWB; seq_len = 5; end
    else if (o == 7'b0100011) begin seq[2] = PH_MA; seq[3] = PH_MW; seq_len = 4; end
    else if (o == 7'b0110011) begin seq[2] = PH_ER; seq[3] = PH_AWB; seq_len = 4; end
    else if (o == 7'b0010011) begin seq[2] = PH_EI; seq[3] = PH_AWB; seq_len = 4; end
    else if (o == 7'b1101111) begin seq[2] = PH_J;  seq[3] = PH_AWB; seq_len = 4; end
    else if (o == 7'b0110111) begin seq[2] = PH_L;  seq[3] = PH_AWB; seq_len = 4; end
    else if (o == 7'b1100011) begin seq[2] = PH_B;  seq_len = 3; end
  endtask

  // Packed {immsrc,pcwrite,adrsrc,memwrite,irwrite,regwrite,resultsrc,alusrca,alusrcb,alucontrol}.
  function automatic logic [16:0] exp_ctrl(input int ph, input logic [6:0] o,
                                            input logic [2:0] f3, input logic f7, input logic z);
    logic pcw = 1'b0, adr = 1'b0, mw = 1'b0, irw = 1'b0, rw = 1'b0;
    logic [1:0] rs = 2'b00, sa = 2'b00, sb = 2'b00;
    logic [2:0] alu = 3'b000;
    case (ph)
      PH_F:   begin irw = 1'b1; pcw = 1'b1; sb = 2'b10; rs = 2'b10; end
      PH_D:   begin sa = 2'b01; sb = 2'b01; end
      PH_MA:  begin sa = 2'b10; sb = 2'b01; end
      PH_MR:  adr = 1'b1;
      PH_MWB: begin rs = 2'b01; rw = 1'b1; end
      PH_MW:  begin adr = 1'b1; mw = 1'b1; end
      PH_ER:  begin sa = 2'b10; alu = ref_alu(o, f3, f7); end
      PH_EI:  begin sa = 2'b10; sb = 2'b01; alu = ref_alu(o, f3, f7); end
      PH_AWB: rw = 1'b1;
      PH_J:   begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
      PH_B:   begin sa = 2'b10; alu = 3'b001; pcw = (f3 == 3'd0) ? z : (f3 == 3'd1) ? ~z : 1'b0; end
      PH_L:   begin sa = 2'b11; sb = 2'b01; end
      default: ;
    endcase
    return {ref_imm(o), pcw, adr, mw, irw, rw, rs, sa, sb, alu};
  endfunction

  task automatic check_ctrl(input string tag, input logic [16:0] e);
    logic [16:0] obs;
    obs = {immsrc, pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc, alusrca, alusrcb, alucontrol};
    n_cmp++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, e);
    end
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    build_seq(o);
    for (int k = 0; k < seq_len; k++) begin
      @(negedge clk);
      check_ctrl($sformatf("op=%b f3=%0d ph=%0d", o, f3, seq[k]), exp_ctrl(seq[k], o, f3, f7, z));
    end
    @(posedge clk); #1;
  endtask

  logic [6:0] legal_ops[7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                               7'b1101111, 7'b1100011, 7'b0110111};

  initial begin
    logic [6:0] ro;
    rst_n = 1'b0; op = 7'b0110111; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    repeat (2) @(negedge clk);
    check_ctrl("reset_outputs", exp_ctrl(PH_F, 7'b0110111, 3'd0, 1'b0, 1'b0));
    @(posedge clk); #1 rst_n = 1'b1;

    run_instr(7'b0000011, 3'd2, 1'b0, 1'b1);   // lw
    run_instr(7'b0100011, 3'd2, 1'b1, 1'b0);   // sw
    run_instr(7'b0110011, 3'd0, 1'b0, 1'b0);   // add
    run_instr(7'b0110011, 3'd0, 1'b1, 1'b0);   // sub
    run_instr(7'b0010011, 3'd0, 1'b1, 1'b0);   // addi, funct7b5 ignored
    run_instr(7'b0110011, 3'd2, 1'b0, 1'b0);   // slt
    run_instr(7'b0110011, 3'd6, 1'b0, 1'b0);   // or
    run_instr(7'b0010011, 3'd7, 1'b0, 1'b0);   // andi
    run_instr(7'b0010011, 3'd4, 1'b0, 1'b0);   // other funct3 -> add
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b1);   // beq taken
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b0);   // beq not taken
    run_instr(7'b1100011, 3'd1, 1'b0, 1'b0);   // bne taken
    run_instr(7'b1100011, 3'd1, 1'b0, 1'b1);   // bne not taken
    run_instr(7'b1100011, 3'd4, 1'b0, 1'b1);   // unsupported branch
    run_instr(7'b1101111, 3'd0, 1'b0, 1'b0);   // jal
    run_instr(7'b0110111, 3'd0, 1'b0, 1'b1);   // lui
    run_instr(7'b0000000, 3'd0, 1'b0, 1'b1);   // illegal

    // Reset pulse in the middle of a load's MEMREAD step.
    op = 7'b0000011; funct3 = 3'd2; funct7b5 = 1'b0; zero = 1'b0;
    build_seq(op);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_ctrl($sformatf("pre_rst ph=%0d", seq[k]), exp_ctrl(seq[k], op, funct3, 1'b0, 1'b0));
    end
    #1 rst_n = 1'b0;
    #1 check_ctrl("async_rst_fetch", exp_ctrl(PH_F, op, funct3, 1'b0, 1'b0));
    @(posedge clk); #1;
    check_ctrl("rst_held_fetch", exp_ctrl(PH_F, op, funct3, 1'b0, 1'b0));
    rst_n = 1'b1;
    run_instr(7'b0000011, 3'd2, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) == 0) ro = 7'($urandom_range(0, 127));
      else ro = legal_ops[$urandom_range(0, 6)];
      run_instr(ro, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 op  in  7  instruction opcode, instr[6:0].
REQ-006 funct3  in  3  instr[14:12].
REQ-007 funct7b5  in  1  instr[30].
REQ-008 zero  in  1  ALU zero flag.
REQ-009 immsrc  out  3  immediate-format select for the extender: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-010 pcwrite  out  1  PC register enable.
REQ-011 adrsrc  out  1  memory address select: 0 PC, 1 result.
REQ-012 memwrite  out  1  data memory write enable.
REQ-013 irwrite  out  1  instruction/oldpc register enable.
REQ-014 regwrite  out  1  register-file write enable.
REQ-015 resultsrc  out  2  00 aluout, 01 data, 10 aluresult.
REQ-016 alusrca  out  2  00 PC, 01 oldpc, 10 rd1, 11 zero.
REQ-017 alusrcb  out  2  00 rd2, 01 immext, 10 constant 4.
REQ-018 alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.

Function
REQ-019 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BRANCH, LUI; one transition per clock.
REQ-020 FETCH->DECODE unconditionally.
REQ-021 DECODE SHALL branch on op: 0000011/0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1101111->JAL, 1100011->BRANCH, 0110111->LUI, any other->FETCH.
REQ-022 MEMADR->MEMREAD for load, ->MEMWRITE for store; MEMREAD->MEMWB; MEMWB, MEMWRITE, BRANCH->FETCH; EXECUTER, EXECUTEI, JAL, LUI->ALUWB; ALUWB->FETCH.
REQ-023 Every output not listed for a state SHALL be 0.
REQ-024 FETCH: adrsrc 0, irwrite 1, alusrca 00, alusrcb 10, add, resultsrc 10, pcwrite 1.
REQ-025 DECODE: alusrca 01, alusrcb 01, add (branch target precompute).
REQ-026 MEMADR: alusrca 10, alusrcb 01, add; MEMREAD: resultsrc 00, adrsrc 1; MEMWB: resultsrc 01, regwrite 1; MEMWRITE: resultsrc 00, adrsrc 1, memwrite 1.
REQ-027 EXECUTER: alusrca 10, alusrcb 00, funct-decoded op; EXECUTEI: alusrca 10, alusrcb 01, funct-decoded op; ALUWB: resultsrc 00, regwrite 1.
REQ-028 JAL: alusrca 01, alusrcb 10, add, resultsrc 00, pcwrite 1; LUI: alusrca 11, alusrcb 01, add.
REQ-029 BRANCH: alusrca 10, alusrcb 00, sub, resultsrc 00; pcwrite = zero for funct3 000, ~zero for 001, 0 otherwise.
REQ-030 Funct decode: 000 -> add, or sub when op[5] and funct7b5 both 1; 010 -> slt; 110 -> or; 111 -> and; other funct3 -> add.
REQ-031 immsrc SHALL be combinational from op in every state: load/0010011 000, store 001, branch 010, jal 011, lui 100, other 000.
REQ-032 Instruction latency: load 5, store 4, R/I/jal/lui 4, branch 3, illegal 2 cycles.
REQ-033 Illegal opcode SHALL produce no memwrite, regwrite or extra pcwrite.

Reset
REQ-034 rst_n low SHALL force state FETCH immediately, including mid-instruction; outputs during reset SHALL equal FETCH outputs.
REQ-035 First rising edge after rst_n release SHALL perform the FETCH transition to DECODE.

Structure
REQ-036 State encoding, immsrc codes, alucontrol codes and opcode constants SHALL live in the shared package used by the extender and ALU.
REQ-037 One sub-module, alu_decoder (aluop, funct3, op5, funct7b5 -> alucontrol), SHALL implement REQ-030.

Verification
REQ-038 lw (op 0000011) -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; immsrc 000; regwrite 1 only in cycle 5.
REQ-039 sw (op 0100011) -> 4 cycles, immsrc 001, memwrite 1 only in MEMWRITE, regwrite never 1.
REQ-040 beq (funct3 000) zero=1 -> pcwrite 1 in BRANCH; zero=0 -> 0; bne inverts; immsrc 010 throughout.
REQ-041 jal -> immsrc 011, pcwrite 1 in FETCH and JAL; lui -> immsrc 100, alusrca 11 in LUI, regwrite in ALUWB.
REQ-042 R-type sub (funct3 000, funct7b5 1) -> alucontrol 001 in EXECUTER; addi with funct7b5 1 -> 000.
REQ-043 rst_n pulsed low during MEMREAD -> state FETCH asynchronously, no MEMWB regwrite; op 0000000 -> DECODE->FETCH, no writes.
